// File: rtl/snake_pixel_renderer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snake_pkg
//  Purpose  : Shared types and default constants for the snake pixel renderer
//  Revision : 1.0  initial release
// ============================================================================
package snake_pkg;
  localparam int COORD_W = 10;

  typedef logic [11:0]        rgb12_t;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int     MAX_SEGS_DEFAULT = 16;
  localparam int     HALF_DEFAULT     = 5;
  localparam rgb12_t HEAD_RGB_DEFAULT = 12'h0F0;
  localparam rgb12_t BODY_RGB_DEFAULT = 12'h00F;
  localparam rgb12_t FOOD_RGB_DEFAULT = 12'hF00;
  localparam rgb12_t BG_RGB_DEFAULT   = 12'hFFF;
endpackage
`default_nettype wire

// File: rtl/snake_pixel_renderer_if.sv
`default_nettype none
// ============================================================================
//  Module   : snake_pixel_renderer_if
//  Purpose  : Video timing, game-state write bus and RGB pins of the renderer
//  Revision : 1.0  initial release
// ============================================================================
interface snake_pixel_renderer_if
  import snake_pkg::*;
#(
  parameter int MAX_SEGS = MAX_SEGS_DEFAULT
);
  localparam int IDXW = (MAX_SEGS > 1) ? $clog2(MAX_SEGS) : 1;

  coord_t          hcount;
  coord_t          vcount;
  logic            h_visable;
  logic            v_visable;
  logic            frame_start;
  logic            black;
  logic            seg_we;
  logic [IDXW-1:0] seg_idx;
  coord_t          seg_x;
  coord_t          seg_y;
  logic            len_we;
  logic [IDXW:0]   snake_len;
  logic            food_we;
  coord_t          food_x;
  coord_t          food_y;
  logic            food_en;
  logic [3:0]      R;
  logic [3:0]      G;
  logic [3:0]      B;

  // Sync counter and game logic side
  modport master (
    output hcount, vcount, h_visable, v_visable, frame_start, black,
    output seg_we, seg_idx, seg_x, seg_y, len_we, snake_len,
    output food_we, food_x, food_y, food_en,
    input  R, G, B
  );

  // Renderer side
  modport slave (
    input  hcount, vcount, h_visable, v_visable, frame_start, black,
    input  seg_we, seg_idx, seg_x, seg_y, len_we, snake_len,
    input  food_we, food_x, food_y, food_en,
    output R, G, B
  );
endinterface
`default_nettype wire

// File: rtl/snake_pixel_renderer_box_hit.sv
`default_nettype none
// ============================================================================
//  Module   : snake_box_hit
//  Purpose  : Tests whether the current pixel lies in a (2*HALF+1) square
//             around a centre; evaluated at 11 bits so nothing wraps
//  Revision : 1.0  initial release
// ============================================================================
module snake_box_hit
  import snake_pkg::*;
#(
  parameter int HALF = HALF_DEFAULT
) (
  input  coord_t hcount,
  input  coord_t vcount,
  input  coord_t cx,
  input  coord_t cy,
  output logic   hit
);
  localparam logic [COORD_W:0] C_HALF = (COORD_W+1)'(HALF);

  logic [COORD_W:0] h11, v11, x11, y11;
  logic             in_x, in_y;

  // Widen by one bit so pixel+HALF and centre+HALF never overflow
  always_comb begin
    h11  = {1'b0, hcount};
    v11  = {1'b0, vcount};
    x11  = {1'b0, cx};
    y11  = {1'b0, cy};
    in_x = (h11 + C_HALF >= x11) && (h11 <= x11 + C_HALF);
    in_y = (v11 + C_HALF >= y11) && (v11 <= y11 + C_HALF);
    hit  = in_x && in_y;
  end
endmodule
`default_nettype wire

// File: rtl/snake_pixel_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : snake_pixel_renderer
//  Purpose  : Snake game pixel colouriser: shadow/active segment register
//             files swapped at frame start, 2-stage hit/priority pipeline
//  Revision : 1.0  initial release
// ============================================================================
module snake_pixel_renderer
  import snake_pkg::*;
#(
  parameter int     MAX_SEGS = MAX_SEGS_DEFAULT,
  parameter int     HALF     = HALF_DEFAULT,
  parameter rgb12_t HEAD_RGB = HEAD_RGB_DEFAULT,
  parameter rgb12_t BODY_RGB = BODY_RGB_DEFAULT,
  parameter rgb12_t FOOD_RGB = FOOD_RGB_DEFAULT,
  parameter rgb12_t BG_RGB   = BG_RGB_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  snake_pixel_renderer_if.slave   bus
);
  localparam int            IDXW      = (MAX_SEGS > 1) ? $clog2(MAX_SEGS) : 1;
  localparam int            LW        = IDXW + 1;
  localparam logic [IDXW:0] C_MAX_LEN = LW'(MAX_SEGS);

  // Shadow (written by game logic) and active (drawn) register files
  coord_t        seg_x_sh_q [MAX_SEGS];
  coord_t        seg_y_sh_q [MAX_SEGS];
  coord_t        seg_x_sh_d [MAX_SEGS];
  coord_t        seg_y_sh_d [MAX_SEGS];
  coord_t        seg_x_act_q[MAX_SEGS];
  coord_t        seg_y_act_q[MAX_SEGS];
  coord_t        seg_x_act_d[MAX_SEGS];
  coord_t        seg_y_act_d[MAX_SEGS];
  logic [IDXW:0] len_sh_q, len_sh_d, len_act_q, len_act_d;
  coord_t        food_x_sh_q, food_x_sh_d, food_y_sh_q, food_y_sh_d;
  logic          food_en_sh_q, food_en_sh_d;
  coord_t        food_x_act_q, food_x_act_d, food_y_act_q, food_y_act_d;
  logic          food_en_act_q, food_en_act_d;

  // Pipeline stage 1 and stage 2 registers
  logic [MAX_SEGS-1:0] seg_hit_raw;
  logic                food_hit_raw;
  logic [MAX_SEGS-1:0] hit_vec_q, hit_vec_d;
  logic                food_hit_q, food_hit_d;
  logic                black_q, black_d;
  logic                vis_q, vis_d;
  rgb12_t              rgb_q, rgb_d;
  logic                body_hit;

  // Shadow writes; active copy reads pre-write shadow so same-cycle writes wait a frame
  always_comb begin
    seg_x_sh_d    = seg_x_sh_q;
    seg_y_sh_d    = seg_y_sh_q;
    len_sh_d      = len_sh_q;
    food_x_sh_d   = food_x_sh_q;
    food_y_sh_d   = food_y_sh_q;
    food_en_sh_d  = food_en_sh_q;
    seg_x_act_d   = seg_x_act_q;
    seg_y_act_d   = seg_y_act_q;
    len_act_d     = len_act_q;
    food_x_act_d  = food_x_act_q;
    food_y_act_d  = food_y_act_q;
    food_en_act_d = food_en_act_q;
    if (bus.seg_we && ({1'b0, bus.seg_idx} < C_MAX_LEN)) begin
      seg_x_sh_d[bus.seg_idx] = bus.seg_x;
      seg_y_sh_d[bus.seg_idx] = bus.seg_y;
    end
    if (bus.len_we) begin
      len_sh_d = (bus.snake_len > C_MAX_LEN) ? C_MAX_LEN : bus.snake_len;
    end
    if (bus.food_we) begin
      food_x_sh_d  = bus.food_x;
      food_y_sh_d  = bus.food_y;
      food_en_sh_d = bus.food_en;
    end
    if (bus.frame_start) begin
      seg_x_act_d   = seg_x_sh_q;
      seg_y_act_d   = seg_y_sh_q;
      len_act_d     = len_sh_q;
      food_x_act_d  = food_x_sh_q;
      food_y_act_d  = food_y_sh_q;
      food_en_act_d = food_en_sh_q;
    end
  end

  // Register file state
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_x_sh_q    <= '{default: '0};
      seg_y_sh_q    <= '{default: '0};
      seg_x_act_q   <= '{default: '0};
      seg_y_act_q   <= '{default: '0};
      len_sh_q      <= '0;
      len_act_q     <= '0;
      food_x_sh_q   <= '0;
      food_y_sh_q   <= '0;
      food_en_sh_q  <= 1'b0;
      food_x_act_q  <= '0;
      food_y_act_q  <= '0;
      food_en_act_q <= 1'b0;
    end else begin
      seg_x_sh_q    <= seg_x_sh_d;
      seg_y_sh_q    <= seg_y_sh_d;
      seg_x_act_q   <= seg_x_act_d;
      seg_y_act_q   <= seg_y_act_d;
      len_sh_q      <= len_sh_d;
      len_act_q     <= len_act_d;
      food_x_sh_q   <= food_x_sh_d;
      food_y_sh_q   <= food_y_sh_d;
      food_en_sh_q  <= food_en_sh_d;
      food_x_act_q  <= food_x_act_d;
      food_y_act_q  <= food_y_act_d;
      food_en_act_q <= food_en_act_d;
    end
  end

  for (genvar gi = 0; gi < MAX_SEGS; gi++) begin : g_seg_hit
    snake_box_hit #(.HALF(HALF)) u_box_hit (
      .hcount (bus.hcount),
      .vcount (bus.vcount),
      .cx     (seg_x_act_q[gi]),
      .cy     (seg_y_act_q[gi]),
      .hit    (seg_hit_raw[gi])
    );
  end

  snake_box_hit #(.HALF(HALF)) u_food_hit (
    .hcount (bus.hcount),
    .vcount (bus.vcount),
    .cx     (food_x_act_q),
    .cy     (food_y_act_q),
    .hit    (food_hit_raw)
  );

  // Stage 1: keep only hits from live segments and an enabled food item
  always_comb begin
    hit_vec_d = '0;
    for (int i = 0; i < MAX_SEGS; i++) begin
      hit_vec_d[i] = seg_hit_raw[i] && (LW'(i) < len_act_q);
    end
    food_hit_d = food_hit_raw && food_en_act_q;
    black_d    = bus.black;
    vis_d      = bus.h_visable && bus.v_visable;
  end

  // Stage 2: colour priority blank > black > head > body > food > background
  always_comb begin
    body_hit = 1'b0;
    for (int i = 1; i < MAX_SEGS; i++) begin
      body_hit = body_hit || hit_vec_q[i];
    end
    rgb_d = BG_RGB;
    if (!vis_q || black_q) begin
      rgb_d = 12'h000;
    end else if (hit_vec_q[0]) begin
      rgb_d = HEAD_RGB;
    end else if (body_hit) begin
      rgb_d = BODY_RGB;
    end else if (food_hit_q) begin
      rgb_d = FOOD_RGB;
    end
  end

  // Pipeline registers; reset flushes both stages
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_vec_q  <= '0;
      food_hit_q <= 1'b0;
      black_q    <= 1'b0;
      vis_q      <= 1'b0;
      rgb_q      <= '0;
    end else begin
      hit_vec_q  <= hit_vec_d;
      food_hit_q <= food_hit_d;
      black_q    <= black_d;
      vis_q      <= vis_d;
      rgb_q      <= rgb_d;
    end
  end

  assign bus.R = rgb_q[11:8];
  assign bus.G = rgb_q[7:4];
  assign bus.B = rgb_q[3:0];
endmodule
`default_nettype wire

// File: tb/tb_snake_pixel_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snake_pixel_renderer
//  Purpose  : Directed self-checking bench for snake_pixel_renderer
//  Revision : 1.0  initial release
// ============================================================================
module tb_snake_pixel_renderer;
  import snake_pkg::*;

  localparam int MAX_SEGS = 16;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  snake_pixel_renderer_if #(.MAX_SEGS(MAX_SEGS)) bus_if ();

  snake_pixel_renderer #(
    .MAX_SEGS (MAX_SEGS),
    .HALF     (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %03h expected %03h", tag, got, exp);
    end
  endtask

  // Present a pixel, wait out the 2-clock latency, compare the colour
  task automatic pix(input string tag, input int h, input int v, input logic [11:0] exp);
    @(negedge clk);
    bus_if.hcount = 10'(h);
    bus_if.vcount = 10'(v);
    repeat (2) @(posedge clk);
    #1;
    check(tag, {bus_if.R, bus_if.G, bus_if.B}, exp);
  endtask

  task automatic wr_seg(input int idx, input int x, input int y, input logic fs);
    @(negedge clk);
    bus_if.seg_we      = 1'b1;
    bus_if.seg_idx     = 4'(idx);
    bus_if.seg_x       = 10'(x);
    bus_if.seg_y       = 10'(y);
    bus_if.frame_start = fs;
    @(negedge clk);
    bus_if.seg_we      = 1'b0;
    bus_if.frame_start = 1'b0;
  endtask

  task automatic wr_len(input int n);
    @(negedge clk);
    bus_if.len_we    = 1'b1;
    bus_if.snake_len = 5'(n);
    @(negedge clk);
    bus_if.len_we    = 1'b0;
  endtask

  task automatic wr_food(input int x, input int y, input logic en);
    @(negedge clk);
    bus_if.food_we = 1'b1;
    bus_if.food_x  = 10'(x);
    bus_if.food_y  = 10'(y);
    bus_if.food_en = en;
    @(negedge clk);
    bus_if.food_we = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    bus_if.frame_start = 1'b1;
    @(negedge clk);
    bus_if.frame_start = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset              = 1'b1;
    bus_if.hcount      = '0;
    bus_if.vcount      = '0;
    bus_if.h_visable   = 1'b1;
    bus_if.v_visable   = 1'b1;
    bus_if.frame_start = 1'b0;
    bus_if.black       = 1'b0;
    bus_if.seg_we      = 1'b0;
    bus_if.seg_idx     = '0;
    bus_if.seg_x       = '0;
    bus_if.seg_y       = '0;
    bus_if.len_we      = 1'b0;
    bus_if.snake_len   = '0;
    bus_if.food_we     = 1'b0;
    bus_if.food_x      = '0;
    bus_if.food_y      = '0;
    bus_if.food_en     = 1'b0;

    // Reset state, then empty screen is background
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", {bus_if.R, bus_if.G, bus_if.B}, 12'h000);
    @(negedge clk);
    reset = 1'b0;
    pix("bg_empty", 50, 50, 12'hFFF);

    // Head at (100,100), visible only after frame_start
    wr_seg(0, 100, 100, 1'b0);
    wr_len(1);
    pix("head_pre_frame", 100, 100, 12'hFFF);
    frame();
    pix("head_edge", 105, 95, 12'h0F0);
    pix("head_outside", 106, 100, 12'hFFF);
    pix("head_corner", 95, 105, 12'h0F0);

    // Body near the origin must not wrap
    wr_seg(1, 3, 2, 1'b0);
    wr_len(2);
    frame();
    pix("body_origin", 0, 0, 12'h00F);
    pix("body_far_edge", 8, 7, 12'h00F);
    pix("body_past_edge", 9, 2, 12'hFFF);
    pix("no_wrap_1020", 1020, 0, 12'hFFF);

    // Head beats food; food alone; disabled food
    wr_seg(0, 200, 200, 1'b0);
    wr_food(200, 200, 1'b1);
    frame();
    pix("head_over_food", 200, 200, 12'h0F0);
    wr_food(300, 300, 1'b1);
    frame();
    pix("food_on", 300, 300, 12'hF00);
    wr_food(300, 300, 1'b0);
    frame();
    pix("food_off", 300, 300, 12'hFFF);

    // Black and blanking override everything
    bus_if.black = 1'b1;
    pix("black_head", 200, 200, 12'h000);
    bus_if.black = 1'b0;
    pix("unblack_head", 200, 200, 12'h0F0);
    bus_if.h_visable = 1'b0;
    pix("h_blank", 200, 200, 12'h000);
    bus_if.h_visable = 1'b1;
    bus_if.v_visable = 1'b0;
    pix("v_blank", 200, 200, 12'h000);
    bus_if.v_visable = 1'b1;

    // Write coinciding with frame_start shows only after the next one
    wr_seg(0, 400, 400, 1'b1);
    pix("same_cycle_new", 400, 400, 12'hFFF);
    pix("same_cycle_old", 200, 200, 12'h0F0);
    frame();
    pix("second_frame_new", 400, 400, 12'h0F0);

    // Length clamp: 31 becomes 16, so index 15 is drawn
    wr_seg(15, 600, 300, 1'b0);
    wr_len(31);
    frame();
    pix("len_clamp_seg15", 600, 300, 12'h00F);
    wr_len(15);
    frame();
    pix("len15_excl_seg15", 600, 300, 12'hFFF);

    // Length 0: no snake, food still drawn
    wr_len(0);
    wr_food(300, 300, 1'b1);
    frame();
    pix("len0_no_head", 400, 400, 12'hFFF);
    pix("len0_food", 300, 300, 12'hF00);

    // Reset mid-frame clears output next cycle and all state
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_frame", {bus_if.R, bus_if.G, bus_if.B}, 12'h000);
    @(negedge clk);
    reset = 1'b0;
    frame();
    pix("post_reset_food", 300, 300, 12'hFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
